// File: rtl/count_seq_checker.sv
// count_seq_checker
//   Watches a 4-bit counter value (cnt_in) and checks that successive sampled
//   values follow a binary or BCD, up or down sequence.
//   It locks on after LOCK_N consecutive correct steps. Each break in the
//   sequence produces a one-cycle err pulse and bumps a saturating error count.
//
// Ports
//   clk        rising-edge clock
//   mstr_reset synchronous active-low reset
//   en         sample strobe; cnt_in is only examined when en=1
//   cnt_type   0 = binary, 1 = BCD
//   cnt_mode   0 = up, 1 = down
//   cnt_in     observed counter value
//   locked     high while in LOCK
//   err        registered one-cycle pulse per sequence error
//   err_cnt    saturating error count (ERR_W bits)
//   exp_out    next value expected on cnt_in (0 while seeking)
//   err_sticky (only with SEQ_CHK_STICKY_EN) set with the first err, cleared
//              only by reset
//
// Build option: define SEQ_CHK_STICKY_EN to add the err_sticky output.

module count_seq_checker #(
  parameter int ERR_W  = 8,
  parameter int LOCK_N = 3
) (
  input  logic             clk,
  input  logic             mstr_reset,
  input  logic             en,
  input  logic             cnt_type,
  input  logic             cnt_mode,
  input  logic [3:0]       cnt_in,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       exp_out
`ifdef SEQ_CHK_STICKY_EN
  , output logic           err_sticky
`endif
);

  localparam logic [1:0] SEEK  = 2'd0;
  localparam logic [1:0] TRACK = 2'd1;
  localparam logic [1:0] LOCK  = 2'd2;

  localparam logic [3:0]       LOCK_V  = 4'(LOCK_N);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [1:0] state;
  logic [3:0] ref_q;
  logic [3:0] match_q;
  logic       type_q;
  logic       mode_q;

  // Successor of v in the selected sequence. In BCD mode the wrap cases
  // (9 going up, 0 going down) are the only special values.
  function automatic logic [3:0] nxt(input logic [3:0] v, input logic t,
                                     input logic m);
    logic [3:0] r;
    if (!t)
      r = m ? v - 4'd1 : v + 4'd1;
    else if (!m)
      r = (v >= 4'd9) ? 4'd0 : v + 4'd1;
    else
      r = (v == 4'd0 || v > 4'd9) ? 4'd9 : v - 4'd1;
    return r;
  endfunction

  logic [3:0] nxt_ref;
  logic       legal;
  logic       mode_chg;
  logic       hit;
  logic       err_set;
  logic [3:0] match_inc;

  always_comb begin
    nxt_ref   = nxt(ref_q, type_q, mode_q);
    legal     = !(cnt_type && cnt_in > 4'd9);
    mode_chg  = (cnt_type != type_q) || (cnt_mode != mode_q);
    hit       = (cnt_in == nxt_ref);
    // A deliberate type/mode switch is a resync, never an error.
    err_set   = en && (state != SEEK) && !mode_chg && !hit;
    match_inc = (match_q >= LOCK_V) ? LOCK_V : match_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!mstr_reset) begin
      state   <= SEEK;
      ref_q   <= 4'd0;
      match_q <= 4'd0;
      type_q  <= 1'b0;
      mode_q  <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      err <= err_set;
      if (en) begin
        if (state == SEEK || mode_chg) begin
          // (Re)acquire: an illegal value just keeps us seeking.
          if (legal) begin
            ref_q   <= cnt_in;
            match_q <= 4'd0;
            type_q  <= cnt_type;
            mode_q  <= cnt_mode;
            state   <= TRACK;
          end else begin
            match_q <= 4'd0;
            state   <= SEEK;
          end
        end else if (hit) begin
          ref_q   <= cnt_in;
          match_q <= match_inc;
          if (match_inc >= LOCK_V) state <= LOCK;
        end else begin
          if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
          ref_q   <= cnt_in;
          match_q <= 4'd0;
          state   <= legal ? TRACK : SEEK;
        end
      end
    end
  end

`ifdef SEQ_CHK_STICKY_EN
  // Rises on the same edge as err so both are seen together.
  always_ff @(posedge clk) begin
    if (!mstr_reset)  err_sticky <= 1'b0;
    else if (err_set) err_sticky <= 1'b1;
  end
`endif

  assign locked  = (state == LOCK);
  assign exp_out = (state == SEEK) ? 4'd0 : nxt_ref;

endmodule

// File: tb/tb_count_seq_checker.sv
module tb_count_seq_checker;

  logic       clk = 1'b0;
  logic       mstr_reset = 1'b0;
  logic       en = 1'b0;
  logic       cnt_type = 1'b0;
  logic       cnt_mode = 1'b0;
  logic [3:0] cnt_in = 4'd0;

  logic       locked, err, locked2, err2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
  logic [3:0] exp_out, exp_out2;
`ifdef SEQ_CHK_STICKY_EN
  logic       err_sticky, err_sticky2;
`endif

  always #5 clk = ~clk;

  count_seq_checker #(.ERR_W(8), .LOCK_N(3)) dut (
    .clk(clk), .mstr_reset(mstr_reset), .en(en), .cnt_type(cnt_type),
    .cnt_mode(cnt_mode), .cnt_in(cnt_in), .locked(locked), .err(err),
    .err_cnt(err_cnt), .exp_out(exp_out)
`ifdef SEQ_CHK_STICKY_EN
    , .err_sticky(err_sticky)
`endif
  );

  // Narrow-counter instance on the same stimulus, for saturation.
  count_seq_checker #(.ERR_W(2), .LOCK_N(3)) dut2 (
    .clk(clk), .mstr_reset(mstr_reset), .en(en), .cnt_type(cnt_type),
    .cnt_mode(cnt_mode), .cnt_in(cnt_in), .locked(locked2), .err(err2),
    .err_cnt(err_cnt2), .exp_out(exp_out2)
`ifdef SEQ_CHK_STICKY_EN
    , .err_sticky(err_sticky2)
`endif
  );

  typedef struct {
    logic       lk;
    logic       er;
    logic [7:0] ec;
    logic [1:0] ec2;
    logic [3:0] ex;
    logic       st;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   errs  = 0;
  logic sticky = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] req);
    tests++;
    assert (obs === req) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // Drive one sample, push its expected post-edge outputs, then pop and
  // compare after the edge.
  task automatic step(input logic r, input logic e, input logic t,
                      input logic m, input logic [3:0] c,
                      input logic xl, input logic xe, input logic [3:0] xx);
    exp_t x, o;
    @(negedge clk);
    mstr_reset = r; en = e; cnt_type = t; cnt_mode = m; cnt_in = c;
    if (!r) begin
      errs = 0; sticky = 1'b0;
    end else if (xe) begin
      if (errs < 255) errs++;
      sticky = 1'b1;
    end
    x.lk = xl; x.er = xe; x.ex = xx; x.st = sticky;
    x.ec  = 8'(errs);
    x.ec2 = (errs > 3) ? 2'd3 : 2'(errs);
    sb.push_back(x);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    chk("locked",   {7'd0, locked},   {7'd0, o.lk});
    chk("err",      {7'd0, err},      {7'd0, o.er});
    chk("err_cnt",  err_cnt,          o.ec);
    chk("exp_out",  {4'd0, exp_out},  {4'd0, o.ex});
    chk("err_cnt2", {6'd0, err_cnt2}, {6'd0, o.ec2});
`ifdef SEQ_CHK_STICKY_EN
    chk("err_sticky", {7'd0, err_sticky}, {7'd0, o.st});
`endif
  endtask

  initial begin
    // reset with an active sample present
    step(0, 1, 0, 0, 4'd5, 0, 0, 4'd0);
    // binary up 0..4, lock after the 4th sample
    step(1, 1, 0, 0, 4'd0, 0, 0, 4'd1);
    step(1, 1, 0, 0, 4'd1, 0, 0, 4'd2);
    step(1, 1, 0, 0, 4'd2, 0, 0, 4'd3);
    step(1, 1, 0, 0, 4'd3, 1, 0, 4'd4);
    step(1, 1, 0, 0, 4'd4, 1, 0, 4'd5);
    // en=0 holds everything
    step(1, 0, 0, 0, 4'd9, 1, 0, 4'd5);
    // 5,6,7 then 9 -> error, resync on 9
    step(1, 1, 0, 0, 4'd5, 1, 0, 4'd6);
    step(1, 1, 0, 0, 4'd6, 1, 0, 4'd7);
    step(1, 1, 0, 0, 4'd7, 1, 0, 4'd8);
    step(1, 1, 0, 0, 4'd9, 0, 1, 4'd10);
    step(1, 0, 0, 0, 4'd0, 0, 0, 4'd10);
    // BCD down 2,1,0,9,8 (type change = silent resync, 0->9 wrap)
    step(1, 1, 1, 1, 4'd2, 0, 0, 4'd1);
    step(1, 1, 1, 1, 4'd1, 0, 0, 4'd0);
    step(1, 1, 1, 1, 4'd0, 0, 0, 4'd9);
    step(1, 1, 1, 1, 4'd9, 1, 0, 4'd8);
    step(1, 1, 1, 1, 4'd8, 1, 0, 4'd7);
    // BCD up lock, then illegal 12 -> error and SEEK, then 3 -> TRACK
    step(1, 1, 1, 0, 4'd3, 0, 0, 4'd4);
    step(1, 1, 1, 0, 4'd4, 0, 0, 4'd5);
    step(1, 1, 1, 0, 4'd5, 0, 0, 4'd6);
    step(1, 1, 1, 0, 4'd6, 1, 0, 4'd7);
    step(1, 1, 1, 0, 4'd12, 0, 1, 4'd0);
    step(1, 1, 1, 0, 4'd3, 0, 0, 4'd4);
    // BCD up 9 -> 0 wrap
    step(1, 1, 1, 0, 4'd7, 0, 1, 4'd8);
    step(1, 1, 1, 0, 4'd8, 0, 0, 4'd9);
    step(1, 1, 1, 0, 4'd9, 0, 0, 4'd0);
    step(1, 1, 1, 0, 4'd0, 1, 0, 4'd1);
    // binary up lock at 7, then mode flip with 8: no error, TRACK, exp 7
    step(1, 1, 0, 0, 4'd4, 0, 0, 4'd5);
    step(1, 1, 0, 0, 4'd5, 0, 0, 4'd6);
    step(1, 1, 0, 0, 4'd6, 0, 0, 4'd7);
    step(1, 1, 0, 0, 4'd7, 1, 0, 4'd8);
    step(1, 1, 0, 1, 4'd8, 0, 0, 4'd7);
    // more errors: counts 4,5,6; narrow counter pinned at 3
    step(1, 1, 0, 1, 4'd3, 0, 1, 4'd2);
    step(1, 1, 0, 1, 4'd0, 0, 1, 4'd15);
    step(1, 1, 0, 1, 4'd0, 0, 1, 4'd15);
    // binary down 0 -> 15 wrap
    step(1, 1, 0, 1, 4'd15, 0, 0, 4'd14);
    // reset on the same edge as a mismatching sample
    step(0, 1, 0, 1, 4'd4, 0, 0, 4'd0);
    step(1, 0, 0, 0, 4'd0, 0, 0, 4'd0);
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard leftover=%0d expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/count_seq_checker.md
COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

Interface
REQ-001 SHALL have parameter ERR_W, default 8: width of the error counter.
REQ-002 SHALL have parameter LOCK_N, default 3: consecutive correct samples needed to reach LOCK (range 1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port mstr_reset, input, 1; reset is synchronous and active-low (0 = reset, sampled on the rising clk edge).
REQ-005 SHALL have port en, input, 1: sample strobe; cnt_in is evaluated only on edges where en=1.
REQ-006 SHALL have port cnt_type, input, 1: 0 = binary sequence, 1 = BCD sequence.
REQ-007 SHALL have port cnt_mode, input, 1: 0 = up, 1 = down.
REQ-008 SHALL have port cnt_in, input, 4: observed counter value.
REQ-009 SHALL have port locked, output, 1: high while the FSM is in LOCK.
REQ-010 SHALL have port err, output, 1: one-cycle pulse per detected sequence error.
REQ-011 SHALL have port err_cnt, output, ERR_W: saturating count of errors.
REQ-012 SHALL have port exp_out, output, 4: expected next cnt_in value.

Function
REQ-013 SHALL compute next(v) as follows. Binary up: (v+1) mod 16. Binary down: (v-1) mod 16. BCD up: 0..8 -> v+1, 9 -> 0. BCD down: 1..9 -> v-1, 0 -> 9.
REQ-014 SHALL treat cnt_in values 10..15 as illegal when cnt_type=1.
REQ-015 SHALL implement FSM states SEEK, TRACK and LOCK, plus registers ref[3:0], match[3:0], type_q and mode_q.
REQ-016 In SEEK, on a sample with legal cnt_in, SHALL do all of: ref<=cnt_in; match<=0; latch type_q/mode_q; go to TRACK. An illegal value SHALL leave the FSM in SEEK and SHALL NOT flag an error.
REQ-017 In TRACK or LOCK, on a sample where cnt_type/cnt_mode equal type_q/mode_q and cnt_in == next(ref), SHALL do all of: ref<=cnt_in; match<=match+1 (saturating at LOCK_N); go to LOCK once match+1 >= LOCK_N.
REQ-018 In TRACK or LOCK, on a sample with unchanged type/mode and cnt_in != next(ref), SHALL do all of: pulse err on the following cycle; increment err_cnt; resync (ref<=cnt_in, match<=0, go to TRACK). If cnt_in is illegal, SHALL go to SEEK instead.
REQ-019 On a sample where cnt_type or cnt_mode differ from type_q/mode_q, SHALL resync as in REQ-016 without flagging an error (intentional mode change).
REQ-020 On cycles with en=0, SHALL hold all state; err SHALL be 0.
REQ-021 err SHALL be registered: it goes high exactly one cycle after the offending sampling edge, for one cycle.
REQ-022 err_cnt SHALL saturate at 2^ERR_W-1 and SHALL NOT wrap.
REQ-023 exp_out SHALL equal next(ref) using type_q/mode_q in TRACK and LOCK, and SHALL be 0 in SEEK.

Reset
REQ-024 With mstr_reset=0 at a clk edge, SHALL set state=SEEK, ref=0, match=0, type_q=0, mode_q=0, locked=0, err=0, err_cnt=0, exp_out=0.
REQ-025 Reset SHALL take priority over en and any in-flight error; an err pending from the same edge SHALL be discarded.

Configuration
REQ-026 With macro SEQ_CHK_STICKY_EN defined, SHALL add output err_sticky (1 bit): set on the same cycle as any err pulse, cleared only by reset.
REQ-027 Without SEQ_CHK_STICKY_EN, the err_sticky port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 Reset, then binary up 0,1,2,3,4 with en=1: locked=1 after the 4th sample (LOCK_N=3), err never asserted, exp_out=5.
REQ-029 BCD down 2,1,0,9,8: no err; 0->9 wrap accepted; locked=1.
REQ-030 Binary up 5,6,7 then 9: err high one cycle after the 9 is sampled; err_cnt=1; locked=0; exp_out=10.
REQ-031 BCD up with cnt_in=12 while locked: err pulse, FSM goes to SEEK, exp_out=0; then sample 3 puts FSM in TRACK with exp_out=4.
REQ-032 Locked binary up at 7, then cnt_mode flipped with cnt_in=8: no err, FSM in TRACK, exp_out=7. Separately, ERR_W=2 with 5 errors: err_cnt=3.
REQ-033 mstr_reset=0 on the same edge as a mismatching sample: err stays 0 and all outputs are zero. With SEQ_CHK_STICKY_EN defined, err_sticky=1 after the first error and held until reset.
